// File: rtl/sum_until_zero_proc_pkg.sv
// Shared types and default widths for the sum-until-zero processor.
package sum_proc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_SUM_WIDTH = 16;
  localparam int DEF_CNT_WIDTH = 8;

endpackage

// File: rtl/sum_until_zero_proc_en_register.sv
// Register with async reset, synchronous clear and load enable; clear wins over load.
module en_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/sum_until_zero_proc.sv
// Accumulates a valid/ready operand stream until a zero operand arrives, then pulses done.
module sum_until_zero_proc
  import sum_proc_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SUM_WIDTH = DEF_SUM_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 busy,
  output logic                 done,
  output logic [SUM_WIDTH-1:0] sum,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow
);

  state_t               state;
  logic                 accept;
  logic                 nz;
  logic                 clr;
  logic                 load;
  logic                 carry;
  logic [SUM_WIDTH-1:0] sum_nx;
  logic [CNT_WIDTH-1:0] cnt_nx;
  logic                 ov_nx;

  // Acceptance is decoded from state so in_ready never depends on in_valid.
  assign accept = in_valid && (state == WAIT);
  assign nz     = |in_data;
  assign clr    = start && (state == IDLE);
  assign load   = accept && nz;

  assign {carry, sum_nx} = {1'b0, sum} + {{(SUM_WIDTH + 1 - WIDTH){1'b0}}, in_data};
  assign cnt_nx = (&count) ? count : count + {{(CNT_WIDTH - 1){1'b0}}, 1'b1};
  assign ov_nx  = overflow | carry;

  en_register #(.WIDTH(SUM_WIDTH)) u_sum (
    .clk(clk), .reset(reset), .clr(clr), .en(load), .d(sum_nx), .q(sum)
  );

  en_register #(.WIDTH(CNT_WIDTH)) u_count (
    .clk(clk), .reset(reset), .clr(clr), .en(load), .d(cnt_nx), .q(count)
  );

  en_register #(.WIDTH(1)) u_overflow (
    .clk(clk), .reset(reset), .clr(clr), .en(load), .d(ov_nx), .q(overflow)
  );

  // Status outputs are registered alongside the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= WAIT;
          in_ready <= 1'b1;
          busy     <= 1'b1;
        end
        WAIT: if (accept && !nz) begin
          state    <= DONE;
          in_ready <= 1'b0;
          done     <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sum_until_zero_proc.md
Name: sum_until_zero_proc

Overview:
Parametrised dedicated processor: control FSM plus datapath that accepts a stream of unsigned operands over a valid/ready handshake and accumulates them until a zero operand arrives.
- Reports sum, operand count, sticky overflow and a one-cycle done pulse.
- Generalises the team's 8-bit mux/flip-flop datapath to configurable operand and accumulator widths, and fills the control-unit role with a real FSM.

Parameters:
WIDTH, 8, operand width in bits
SUM_WIDTH, 16, accumulator width in bits (must be >= WIDTH)
CNT_WIDTH, 8, operand-counter width in bits

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; all state cleared immediately
start  input  1  begin a new computation; sampled only in IDLE
in_valid  input  1  in_data holds a valid operand
in_ready  output  1  block can accept an operand this cycle
in_data  input  WIDTH  unsigned operand; value 0 terminates the stream
busy  output  1  high in WAIT and DONE states
done  output  1  one-cycle pulse when result is final
sum  output  SUM_WIDTH  accumulated sum, modulo 2^SUM_WIDTH
count  output  CNT_WIDTH  number of non-zero operands accepted, saturating
overflow  output  1  sticky: set if any addition carried out of SUM_WIDTH

Behaviour:
- Reset (async, active-high) forces:
  - state = IDLE
  - sum = 0, count = 0, overflow = 0
  - done = 0, busy = 0, in_ready = 0
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - in_ready = 0, busy = 0.
  - On start = 1: sum, count and overflow clear to 0 and the FSM moves to WAIT on the same edge.
  - Outputs hold the previous result until that edge.
- WAIT:
  - in_ready = 1, busy = 1.
  - An operand is accepted on a rising edge where in_valid && in_ready.
  - Accepted operand, in_data != 0:
    - sum <= sum + zero_extend(in_data), wrapping modulo 2^SUM_WIDTH.
    - overflow <= overflow | carry_out.
    - count <= count + 1, saturating at 2^CNT_WIDTH − 1.
    - Stay in WAIT; back-to-back operands are accepted every cycle.
  - Accepted operand, in_data == 0: sum and count are unchanged; go to DONE.
  - in_valid = 0: no state change (stall of any length).
- DONE:
  - done = 1 and busy = 1 for exactly one cycle, in_ready = 0.
  - Next edge: go to IDLE unconditionally.
  - done is asserted in the cycle immediately after the zero operand is accepted.
- start outside IDLE is ignored, including start during DONE. A start presented in the IDLE cycle after DONE begins a new run.
- The result (sum, count, overflow) is stable from DONE until the next accepted start or reset.
- Reset mid-operation (any state) aborts the run; all outputs return to reset values asynchronously, and no done pulse is produced.
- All outputs are registered or decoded from state only; there is no combinational path from in_valid or in_data to any output.
- Latency: N non-zero operands plus the terminator with no stalls → done pulses N+2 cycles after the start edge.

Decomposition:
- Shared package `sum_proc_pkg`:
  - state enum {IDLE, WAIT, DONE}, 2-bit encoding.
  - Default width constants.
- Sub-module `en_register`:
  - Parametrised WIDTH.
  - Async active-high reset to 0, synchronous clear, load enable.
  - Instantiated for the sum, count and overflow registers, replacing the single-bit flip-flop plus external mux pattern.
- The FSM stays inline in the top module.

Test Plan:
- Reset asserted mid-cycle while in IDLE with prior result → sum = 0, count = 0, overflow = 0, done = 0, busy = 0 before the next clock edge.
- Defaults; start; operands 5, 3, 7, 0 back-to-back → sum = 15, count = 3, overflow = 0, one done pulse on the cycle after the 0 is accepted, busy low afterwards.
- WIDTH = 8, SUM_WIDTH = 8; operands 200, 100, 0 → sum = 44, count = 2, overflow = 1; a following run 1, 0 → sum = 1, overflow = 0.
- start then immediate 0 → done pulse, sum = 0, count = 0; then in_valid low for 10 cycles inside a second run (4, stall, 6, 0) → sum = 10, count = 2, no acceptance while stalled.
- start pulsed in WAIT and in DONE → ignored, result unchanged; reset asserted in WAIT after operands 9, 9 → all outputs 0, no done pulse, FSM in IDLE.
- CNT_WIDTH = 2; operands 1, 1, 1, 1, 1, 0 → count = 3 (saturated), sum = 5.
